// File: rtl/sha256_mem_responder.sv
// Memory-side responder for a SHA-256 core. It holds the message/output RAM, launches a hash
// on host request, and collects the eight digest words the core writes into the output window.
//
// state    | meaning
// IDLE     | waiting for host_go; host owns the RAM write port
// LAUNCH   | one-cycle start pulse to the core
// WAIT_ACK | waiting up to 4 cycles for the core to drop done
// RUN      | core hashing; output-window writes are captured
// FINISH   | judge capture mask, then return to IDLE
module sha256_mem_responder #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [15:0] MSG_BASE = 16'h0000,
    parameter logic [15:0] OUT_BASE = 16'h0080
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         host_we,
    input  logic [15:0]  host_addr,
    input  logic [31:0]  host_wdata,
    input  logic         host_go,
    output logic         host_busy,
    output logic         start,
    input  logic         done,
    output logic [15:0]  message_addr,
    output logic [15:0]  output_addr,
    input  logic         mem_we,
    input  logic [15:0]  mem_addr,
    input  logic [31:0]  mem_write_data,
    output logic [31:0]  mem_read_data,
    output logic         hash_valid,
    output logic [255:0] hash_out,
    output logic         err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_ACK, S_RUN, S_FINISH
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [1:0]     r_ack_cnt;
    logic [1:0]     w_ack_cnt_nx;
    logic [31:0]    r_mem [DEPTH];
    logic [31:0]    r_rdata;
    logic           r_valid;
    logic [255:0]   r_hash;
    logic [7:0]     r_mask;
    logic           r_err;

    logic           w_core_in_range;
    logic           w_host_in_range;
    logic           w_core_wr;
    logic           w_host_wr;
    logic           w_host_err;
    logic [16:0]    w_out_off;
    logic           w_out_hit;
    logic           w_capture;
    logic [2:0]     w_slot;
    logic           w_go_ok;
    logic           w_go_err;
    logic           w_ack_to;
    logic           w_fin_ok;
    logic           w_fin_bad;

    assign w_core_in_range = ({16'h0000, mem_addr} < DEPTH);
    assign w_host_in_range = ({16'h0000, host_addr} < DEPTH);
    assign w_core_wr       = mem_we & w_core_in_range;
    assign w_host_wr       = host_we & ~host_busy & w_host_in_range;
    assign w_host_err      = host_we & (host_busy | ~w_host_in_range);

    // 17-bit offset so the window never wraps past 16'hFFFF
    assign w_out_off = {1'b0, mem_addr} - {1'b0, OUT_BASE};
    assign w_out_hit = (mem_addr >= OUT_BASE) && (w_out_off < 17'd8);
    assign w_slot    = w_out_off[2:0];
    assign w_capture = w_core_wr & w_out_hit & (r_state == S_RUN);

    // Core wins a same-edge collision with the host on one address
    always_ff @(posedge clk) begin
        if (w_host_wr) r_mem[host_addr[AW-1:0]] <= host_wdata;
        if (w_core_wr) r_mem[mem_addr[AW-1:0]]  <= mem_write_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdata <= '0;
        else          r_rdata <= w_core_in_range ? r_mem[mem_addr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ack_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ack_cnt <= w_ack_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_ack_cnt_nx = r_ack_cnt;
        w_go_ok      = 1'b0;
        w_go_err     = 1'b0;
        w_ack_to     = 1'b0;
        w_fin_ok     = 1'b0;
        w_fin_bad    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host_go) begin
                    if (done) begin
                        w_state_nx = S_LAUNCH;
                        w_go_ok    = 1'b1;
                    end else begin
                        w_go_err   = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                w_state_nx   = S_WAIT_ACK;
                w_ack_cnt_nx = 2'd3;
            end
            S_WAIT_ACK: begin
                if (!done) begin
                    w_state_nx = S_RUN;
                end else if (r_ack_cnt == 2'd0) begin
                    w_state_nx = S_IDLE;
                    w_ack_to   = 1'b1;
                end else begin
                    w_ack_cnt_nx = r_ack_cnt - 2'd1;
                end
            end
            S_RUN: begin
                if (done) w_state_nx = S_FINISH;
            end
            S_FINISH: begin
                w_state_nx = S_IDLE;
                if (&r_mask) w_fin_ok  = 1'b1;
                else         w_fin_bad = 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_hash  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_go_ok) begin
                r_valid <= 1'b0;
                r_mask  <= '0;
            end else if (w_fin_ok) begin
                r_valid <= 1'b1;
            end
            for (int k = 0; k < 8; k++) begin
                if (w_capture && (w_slot == 3'(k))) begin
                    r_hash[255-32*k -: 32] <= mem_write_data;
                    r_mask[k]              <= 1'b1;
                end
            end
            // No read strobe exists, so an out-of-range core address is an error on any edge
            if (w_go_err || w_ack_to || w_fin_bad || w_host_err || !w_core_in_range)
                r_err <= 1'b1;
        end
    end

    assign host_busy     = (r_state != S_IDLE);
    assign start         = (r_state == S_LAUNCH);
    assign message_addr  = MSG_BASE;
    assign output_addr   = OUT_BASE;
    assign mem_read_data = r_rdata;
    assign hash_valid    = r_valid;
    assign hash_out      = r_hash;
    assign err           = r_err;
endmodule

// File: tb/tb_sha256_mem_responder.sv
// Self-checking bench for sha256_mem_responder: vector table for the RAM port, directed
// corner-case runs and randomized hash runs against a behavioural model.
module tb_sha256_mem_responder;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         host_we;
    logic [15:0]  host_addr;
    logic [31:0]  host_wdata;
    logic         host_go;
    logic         host_busy;
    logic         start;
    logic         done;
    logic [15:0]  message_addr;
    logic [15:0]  output_addr;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic         hash_valid;
    logic [255:0] hash_out;
    logic         err;

    sha256_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_go(host_go), .host_busy(host_busy),
        .start(start), .done(done),
        .message_addr(message_addr), .output_addr(output_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .hash_valid(hash_valid), .hash_out(hash_out), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_go    = 0;

    logic [31:0] model_mem [256];
    logic [31:0] exp_hash [8];
    logic        exp_valid;
    logic        exp_err;

    logic [15:0] wr_addr [16];
    logic [31:0] wr_data [16];

    typedef struct {
        logic        hwe;
        logic [15:0] haddr;
        logic [31:0] hdata;
        logic        cwe;
        logic [15:0] caddr;
        logic [31:0] cdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (start === 1'b1) n_start++;
    endtask

    function automatic logic [255:0] packed_hash();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[255-32*k -: 32] = exp_hash[k];
        return v;
    endfunction

    task automatic do_reset();
        host_we = 1'b0; host_go = 1'b0; mem_we = 1'b0; mem_addr = 16'h0; done = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_start", start, 1'b0);
        chk("rst_busy", host_busy, 1'b0);
        chk("rst_valid", hash_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_hash", hash_out, 256'h0);
        chk("rst_rdata", mem_read_data, 32'h0);
        exp_err = 1'b0;
        exp_valid = 1'b0;
        for (int k = 0; k < 8; k++) exp_hash[k] = 32'h0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    // One complete host_go run: w = WAIT_ACK cycles with done still high (>=4 times out),
    // then a read of rd_addr (optionally with an illegal host write), then nwr core writes.
    task automatic run_core(input int w, input int nwr, input logic [15:0] rd_addr, input bit poke);
        logic [7:0]  mask;
        logic [15:0] a;
        mask = 8'h00;
        chk("pre_idle", host_busy, 1'b0);
        done = 1'b1; host_go = 1'b1;
        step();
        host_go = 1'b0; n_go++;
        exp_valid = 1'b0;
        chk("launch_start", start, 1'b1);
        chk("launch_busy", host_busy, 1'b1);
        step();
        chk("start_one_cycle", start, 1'b0);
        for (int i = 0; i < w && i < 4; i++) step();
        if (w >= 4) begin
            exp_err = 1'b1;
            chk("to_busy", host_busy, 1'b0);
            chk("to_err", err, exp_err);
            chk("to_valid", hash_valid, 1'b0);
            chk("to_hash", hash_out, packed_hash());
            return;
        end
        done = 1'b0;
        step();
        chk("run_busy", host_busy, 1'b1);
        mem_addr = rd_addr; host_go = 1'b1;
        if (poke) begin
            host_we = 1'b1; host_addr = rd_addr; host_wdata = ~model_mem[rd_addr[7:0]];
        end
        step();
        chk("run_read", mem_read_data, model_mem[rd_addr[7:0]]);
        host_go = 1'b0; host_we = 1'b0;
        if (poke) exp_err = 1'b1;
        chk("run_err", err, exp_err);
        for (int i = 0; i < nwr; i++) begin
            a = wr_addr[i];
            mem_we = 1'b1; mem_addr = a; mem_write_data = wr_data[i];
            step();
            chk("wr_old_data", mem_read_data, model_mem[a[7:0]]);
            model_mem[a[7:0]] = wr_data[i];
            if (a >= 16'h0080 && a <= 16'h0087) begin
                exp_hash[a - 16'h0080] = wr_data[i];
                mask[a - 16'h0080] = 1'b1;
            end
        end
        mem_we = 1'b0; mem_addr = 16'h0; done = 1'b1;
        step();
        chk("fin_busy", host_busy, 1'b1);
        chk("fin_valid", hash_valid, 1'b0);
        if (mask == 8'hFF) exp_valid = 1'b1;
        else               exp_err   = 1'b1;
        step();
        chk("end_busy", host_busy, 1'b0);
        chk("end_valid", hash_valid, exp_valid);
        chk("end_err", err, exp_err);
        chk("end_hash", hash_out, packed_hash());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 16'h0,   32'h0,         1'b0, 16'h0005, 32'h0,         32'h0000_0005, 1'b0};
        tbl[1] = '{1'b0, 16'h0,   32'h0,         1'b0, 16'h0013, 32'h0,         32'h0000_0013, 1'b0};
        tbl[2] = '{1'b0, 16'h0,   32'h0,         1'b1, 16'h0007, 32'hDEAD_BEEF, 32'h0000_0007, 1'b0};
        tbl[3] = '{1'b0, 16'h0,   32'h0,         1'b0, 16'h0007, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[4] = '{1'b0, 16'h0,   32'h0,         1'b1, 16'h0085, 32'h1234_5678, 32'h1000_0085, 1'b0};
        tbl[5] = '{1'b1, 16'h30,  32'h0BAD_F00D, 1'b0, 16'h0085, 32'h0,         32'h1234_5678, 1'b0};
        tbl[6] = '{1'b0, 16'h0,   32'h0,         1'b0, 16'h0030, 32'h0,         32'h0BAD_F00D, 1'b0};
        tbl[7] = '{1'b0, 16'h0,   32'h0,         1'b0, 16'h0100, 32'h0,         32'h0000_0000, 1'b1};
        tbl[8] = '{1'b0, 16'h0,   32'h0,         1'b1, 16'h0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[9] = '{1'b0, 16'h0,   32'h0,         1'b0, 16'h0000, 32'h0,         32'h0000_0000, 1'b1};

        reset_n = 1'b1; host_addr = 16'h0; host_wdata = 32'h0; mem_write_data = 32'h0;
        do_reset();
        chk("msg_addr", message_addr, 16'h0000);
        chk("out_addr", output_addr, 16'h0080);

        for (int i = 0; i < 256; i++) begin
            host_we = 1'b1; host_addr = 16'(i);
            host_wdata = (i < 20) ? 32'(i) : 32'h1000_0000 + 32'(i);
            step();
            model_mem[i] = host_wdata;
        end
        host_we = 1'b0;

        for (int i = 0; i < 10; i++) begin
            host_we = tbl[i].hwe; host_addr = tbl[i].haddr; host_wdata = tbl[i].hdata;
            mem_we = tbl[i].cwe; mem_addr = tbl[i].caddr; mem_write_data = tbl[i].cdata;
            step();
            chk($sformatf("vec%0d_rdata", i), mem_read_data, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
            if (tbl[i].hwe && tbl[i].haddr < 16'd256) model_mem[tbl[i].haddr[7:0]] = tbl[i].hdata;
            if (tbl[i].cwe && tbl[i].caddr < 16'd256) model_mem[tbl[i].caddr[7:0]] = tbl[i].cdata;
        end
        host_we = 1'b0; mem_we = 1'b0; mem_addr = 16'h0;
        chk("idle_write_no_capture", hash_out, 256'h0);

        do_reset();
        host_we = 1'b1; host_addr = 16'h0200; host_wdata = 32'h1;
        step();
        host_we = 1'b0;
        chk("host_oob_err", err, 1'b1);

        do_reset();
        done = 1'b0; host_go = 1'b1;
        step();
        host_go = 1'b0;
        chk("go_not_done_busy", host_busy, 1'b0);
        chk("go_not_done_err", err, 1'b1);
        done = 1'b1;
        step();
        chk("go_not_done_busy2", host_busy, 1'b0);

        do_reset();
        wr_data[0] = 32'hBA78_16BF; wr_data[1] = 32'h8F01_CFEA;
        wr_data[2] = 32'h4141_40DE; wr_data[3] = 32'h5DAE_2223;
        wr_data[4] = 32'hB003_61A3; wr_data[5] = 32'h9617_7A9C;
        wr_data[6] = 32'hB410_FF61; wr_data[7] = 32'hF200_15AD;
        for (int i = 0; i < 8; i++) wr_addr[i] = 16'h0080 + 16'(i);
        run_core(1, 8, 16'h0005, 1'b0);
        chk("abc_word0", hash_out[255:224], 32'hBA78_16BF);

        do_reset();
        run_core(0, 7, 16'h0011, 1'b0);

        do_reset();
        run_core(4, 0, 16'h0000, 1'b0);

        do_reset();
        run_core(2, 8, 16'h0003, 1'b1);
        mem_addr = 16'h0003;
        step();
        chk("poke_ram_unchanged", mem_read_data, model_mem[3]);
        mem_addr = 16'h0;

        do_reset();
        done = 1'b1; host_go = 1'b1;
        step();
        host_go = 1'b0; n_go++;
        step();
        done = 1'b0;
        step();
        mem_we = 1'b1; mem_addr = 16'h0080; mem_write_data = 32'h55AA_55AA;
        step();
        model_mem[8'h80] = 32'h55AA_55AA;
        chk("midrun_busy", host_busy, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_idle", host_busy, 1'b0);
        chk("post_rst_no_start", n_start, n_go);
        for (int i = 0; i < 8; i++) begin
            wr_addr[i] = 16'h0087 - 16'(i); wr_data[i] = $urandom;
        end
        run_core(3, 8, 16'h0080, 1'b0);

        for (int it = 0; it < 24; it++) begin
            int nwr;
            do_reset();
            if ($urandom_range(0, 1) == 1) begin
                nwr = 8 + $urandom_range(0, 3);
                for (int i = 0; i < nwr; i++)
                    wr_addr[i] = (i < 8) ? 16'h0080 + 16'(i) : 16'h0080 + 16'($urandom_range(0, 7));
            end else begin
                nwr = $urandom_range(1, 10);
                for (int i = 0; i < nwr; i++) wr_addr[i] = 16'h007C + 16'($urandom_range(0, 15));
            end
            for (int i = 0; i < nwr; i++) wr_data[i] = $urandom;
            run_core($urandom_range(0, 5), nwr, 16'($urandom_range(0, 255)), 1'b0);
        end

        chk("start_pulse_count", n_start, n_go);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
